// File: rtl/sha256_round_engine.sv
// sha256_round_engine: sequential SHA-256 compression, one round per cycle.
// Accepts a 512-bit block, runs 64 rounds with K[t] read from an external
// coefficient table, then folds the working variables into H.
// Optional macro SHA256_CHAIN_EN: adds i_first and chains H across blocks.
module sha256_round_engine (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_block_valid,
    output logic         o_block_ready,
    input  logic [511:0] i_block,
`ifdef SHA256_CHAIN_EN
    input  logic         i_first,
`endif
    output logic [6:0]   o_coef_num,
    input  logic [31:0]  i_coef_value,
    output logic         o_digest_valid,
    output logic [255:0] o_digest
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    state_t        state, state_nxt;
    logic [5:0]    t;
    logic [255:0]  h_state;
    logic          digest_valid;
    logic [31:0]   a, b, c, d, e, f, g, h;
    logic [31:0]   w [16];           // w[0] is W[t], w[15] is W[t+15]
    logic [31:0]   t1, t2, w_new;
    logic [255:0]  h_base;           // value the round result is added to
    logic [255:0]  h_init;           // value a..h start from on accept

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef SHA256_CHAIN_EN
    assign h_base = h_state;
    assign h_init = i_first ? IV : h_state;
`else
    assign h_base = IV;
    assign h_init = IV;
`endif

    // Round arithmetic and message-schedule extension, all mod 2^32.
    assign t1    = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + i_coef_value + w[0];
    assign t2    = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

    assign o_digest       = h_state;
    assign o_digest_valid = digest_valid;

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and handshake/coefficient outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt     = state;
        o_block_ready = 1'b0;
        o_coef_num    = 7'd0;
        case (state)
            S_IDLE: begin
                o_block_ready = 1'b1;
                if (i_block_valid) state_nxt = S_ROUND;
            end
            S_ROUND: begin
                o_coef_num = {1'b0, t};
                if (t == 6'd63) state_nxt = S_FINAL;
            end
            S_FINAL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round counter, hash state and digest pulse; all reset to the IV state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            t            <= 6'd0;
            h_state      <= IV;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_block_valid) begin
                        t <= 6'd0;
`ifdef SHA256_CHAIN_EN
                        if (i_first) h_state <= IV;
`endif
                    end
                end
                S_ROUND: t <= t + 6'd1;
                S_FINAL: begin
                    h_state <= {h_base[255:224] + a, h_base[223:192] + b,
                                h_base[191:160] + c, h_base[159:128] + d,
                                h_base[127:96]  + e, h_base[95:64]   + f,
                                h_base[63:32]   + g, h_base[31:0]    + h};
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Working variables and message window: loaded on accept, shifted per round.
    // NOTE: this datapath has no reset; it is always reloaded on accept before use.
    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_block_valid) begin
            {a, b, c, d, e, f, g, h} <= h_init;
            for (int i = 0; i < 16; i++) w[i] <= i_block[511 - 32*i -: 32];
        end else if (state == S_ROUND) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end

endmodule
